// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard sources in, pipeline control and
// event counters out. The controller side uses the slave modport.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int EVT_W = 16
);
  logic [REG_W-1:0] IDrs;
  logic [REG_W-1:0] IDrt;
  logic             IDUsesRt;
  logic             IDIsJr;
  logic [REG_W-1:0] IDEXrt;
  logic             IDEXMemRead;
  logic             IDEXRegWrite;
  logic [REG_W-1:0] IDEXrd;
  logic             Branch;
  logic             ControlMux;
  logic             IFIDWrite;
  logic             PCWrite;
  logic             Flush;
  logic [EVT_W-1:0] StallEvents;
  logic [EVT_W-1:0] FlushEvents;

  modport slave (
    input  IDrs, IDrt, IDUsesRt, IDIsJr, IDEXrt, IDEXMemRead, IDEXRegWrite,
           IDEXrd, Branch,
    output ControlMux, IFIDWrite, PCWrite, Flush, StallEvents, FlushEvents
  );

  modport master (
    output IDrs, IDrt, IDUsesRt, IDIsJr, IDEXrt, IDEXMemRead, IDEXRegWrite,
           IDEXrd, Branch,
    input  ControlMux, IFIDWrite, PCWrite, Flush, StallEvents, FlushEvents
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and jr-operand stalls, multi-slot
// branch flushes, and saturating stall/flush event counters.
//
// state | meaning
// IDLE  | normal flow; hazards decoded combinationally (Mealy outputs)
// STALL | remaining cycles of a multi-cycle load-use stall; inputs ignored
// FLUSH | remaining cycles of a multi-slot branch flush; inputs ignored
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int EVT_W       = 16
) (
  input logic          Clk,
  input logic          Reset,
  hazard_ctrl_if.slave hz
);

  localparam int MAX_LEN = (LOAD_STALL > FLUSH_DEPTH) ? LOAD_STALL : FLUSH_DEPTH;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0] stall_evt_q, flush_evt_q;

  logic lu, jh, stall_evt, flush_evt;
  logic ctrl_mux, ifid_we, pc_we, flush;

  // Hazard decode; register 0 never matches anything.
  always_comb begin
    lu = hz.IDEXMemRead &&
         (((hz.IDEXrt != '0) && (hz.IDEXrt == hz.IDrs)) ||
          (hz.IDUsesRt && (hz.IDEXrt != '0) && (hz.IDEXrt == hz.IDrt)));
    jh = hz.IDIsJr && hz.IDEXRegWrite && (hz.IDEXrd != '0) &&
         (hz.IDEXrd == hz.IDrs) && !lu;
    stall_evt = (state_q == IDLE) && (lu || jh);
    flush_evt = (state_q == IDLE) && !lu && !jh && hz.Branch;
  end

  // State and down-counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: IDLE only leaves when a hazard needs more than one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lu) begin
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            cnt_d   = CNT_W'(LOAD_STALL - 1);
          end
        end else if (!jh && hz.Branch) begin
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          end
        end
      end
      STALL, FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: Mealy in IDLE, state-only elsewhere, pass values while in reset.
  always_comb begin
    ctrl_mux = 1'b1;
    ifid_we  = 1'b1;
    pc_we    = 1'b1;
    flush    = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        IDLE: begin
          if (lu || jh) begin
            ctrl_mux = 1'b0;
            ifid_we  = 1'b0;
            pc_we    = 1'b0;
          end else if (hz.Branch) begin
            flush = 1'b1;
          end
        end
        STALL: begin
          ctrl_mux = 1'b0;
          ifid_we  = 1'b0;
          pc_we    = 1'b0;
        end
        FLUSH: flush = 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating event counters; one count per detected event, not per cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_evt_q <= '0;
      flush_evt_q <= '0;
    end else begin
      if (stall_evt && (stall_evt_q != '1)) stall_evt_q <= stall_evt_q + EVT_W'(1);
      if (flush_evt && (flush_evt_q != '1)) flush_evt_q <= flush_evt_q + EVT_W'(1);
    end
  end

  assign hz.ControlMux  = ctrl_mux;
  assign hz.IFIDWrite   = ifid_we;
  assign hz.PCWrite     = pc_we;
  assign hz.Flush       = flush;
  assign hz.StallEvents = stall_evt_q;
  assign hz.FlushEvents = flush_evt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline. It sits beside the ID stage and drives the PC write enable, IF/ID write enable, control-bubble mux and IF/ID flush. It handles load-use stalls of configurable length for multi-cycle data memory, JR-operand stalls, and multi-slot branch flushes, all through a small counter-based state machine. It also keeps saturating stall and flush event counters for performance measurement.

## Interface
Parameters:
- REG_W, 5, register address width
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (>=1)
- FLUSH_DEPTH, 1, cycles Flush is held per taken branch (>=1)
- EVT_W, 16, width of event counters

Ports:
- Clk  in  1  pipeline clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high
- IDrs  in  REG_W  rs field of instruction in ID
- IDrt  in  REG_W  rt field of instruction in ID
- IDUsesRt  in  1  ID instruction reads rt (R-type, store, beq)
- IDIsJr  in  1  ID instruction is jr
- IDEXrt  in  REG_W  destination (rt) of instruction in EX
- IDEXMemRead  in  1  EX instruction is a load
- IDEXRegWrite  in  1  EX instruction writes a register
- IDEXrd  in  REG_W  final destination register of EX instruction
- Branch  in  1  taken branch/jump resolved in ID this cycle
- ControlMux  out  1  1 = pass ID control to ID/EX, 0 = insert bubble
- IFIDWrite  out  1  IF/ID register load enable
- PCWrite  out  1  PC load enable
- Flush  out  1  clear IF/ID to nop
- StallEvents  out  EVT_W  saturating count of stall events
- FlushEvents  out  EVT_W  saturating count of branch flush events

## Operation
- Register 0 never creates a hazard; any comparison against address 0 is false.
- Load-use hazard (LU): IDEXMemRead && (IDEXrt==IDrs || (IDUsesRt && IDEXrt==IDrt)).
- JR hazard (JH): IDIsJr && IDEXRegWrite && IDEXrd==IDrs && !LU.
- Stall outputs: ControlMux=0, IFIDWrite=0, PCWrite=0, Flush=0.
- Pass outputs: ControlMux=1, IFIDWrite=1, PCWrite=1, Flush=0.
- States: IDLE, STALL, FLUSH. A down-counter of width clog2(max(LOAD_STALL,FLUSH_DEPTH)+1) is used.
- IDLE:
  - If LU: drive stall outputs this cycle, and count one StallEvent. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1.
  - Else if JH: drive stall outputs for exactly one cycle, count one StallEvent, stay in IDLE.
  - Else if Branch: drive pass outputs with Flush=1, and count one FlushEvent. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1.
  - Else: drive pass outputs.
- STALL: drive stall outputs and ignore all inputs. Decrement cnt; when cnt==1 at the edge, return to IDLE.
- FLUSH: drive pass outputs with Flush=1 and ignore all inputs, including Branch. Decrement cnt; when cnt==1, return to IDLE.
- Priority on simultaneous events: LU > JH > Branch. A branch seen during a stall is dropped. The branch instruction is still held in ID and re-resolves once the stall releases.
- Event counters increment once per event (not per cycle), saturate at all-ones, and never wrap.

## Timing
- Outputs are Mealy in IDLE: a hazard is reflected combinationally in the same cycle it is presented. In STALL and FLUSH, outputs depend only on state.
- LU total stall = LOAD_STALL consecutive cycles, starting with the detection cycle.
- Branch flush = FLUSH_DEPTH consecutive cycles of Flush=1, starting with the Branch cycle.
- JH stall = 1 cycle.
- After a stall releases, the EX stage holds a bubble (IDEXMemRead=0), so the same hazard is not re-detected.
- Reset (asynchronous, while high):
  - State=IDLE, cnt=0, StallEvents=0, FlushEvents=0.
  - Outputs forced to pass values (ControlMux=1, IFIDWrite=1, PCWrite=1, Flush=0) regardless of inputs.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately. The first edge after deassertion evaluates from IDLE.

## Test plan
- LOAD_STALL=1, IDEXMemRead=1, IDEXrt=5, IDrs=5 for one cycle -> stall outputs in that cycle only; StallEvents=1.
- LOAD_STALL=3, same hazard, then IDEXMemRead=0 -> ControlMux/PCWrite/IFIDWrite=0 for exactly 3 cycles, then 1; StallEvents=1.
- IDEXrt=0, IDrs=0, IDEXMemRead=1 -> no stall. IDUsesRt=0 with IDrt==IDEXrt=7 -> no stall.
- FLUSH_DEPTH=2, Branch pulse plus a second Branch on the next cycle -> Flush=1 for exactly 2 cycles with PCWrite=1 throughout; FlushEvents=1.
- LU and Branch in the same cycle -> stall only, Flush=0; FlushEvents unchanged.
- IDIsJr=1, IDEXRegWrite=1, IDEXrd=IDrs=31 -> 1-cycle stall.
- Reset raised in the 2nd cycle of a 3-cycle stall -> outputs return to pass values immediately and counters clear.
- Force the counter to the all-ones value (EVT_W=4, 16 stall events) -> StallEvents holds at 15.
